// File: rtl/ext_uart_tx.sv
// Write-only 8N1 UART transmitter on the SoC external byte bus.
// Bytes written to TXDATA are queued in a FIFO; a full FIFO back-pressures the bus.
`timescale 1ns/1ps
module ext_uart_tx #(
    parameter int          DEPTH       = 16,
    parameter int          AW          = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd416
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [15:0]   i_ext_addr,
    input  logic [7:0]    i_ext_data,
    input  logic          i_ext_wstrb,
    input  logic          i_ext_valid,
    output logic          o_ext_ready,
    output logic          o_uart_tx,
    output logic          o_busy,
    output logic [AW:0]   o_fifo_level
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] level_s;
    logic [7:0]  rdata_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;

    logic        seen_r;
    logic        ready_s;
    logic        accept_s;
    logic        txdata_sel_s;
    logic        unused_addr_s;
    logic [15:0] div_r;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic [15:0] wdiv_r;
    logic [15:0] wdiv_next_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_next_s;
    logic [2:0]  bit_r;
    logic [2:0]  bit_next_s;
    logic        tx_r;
    logic        tx_next_s;

    assign level_s       = wr_ptr_r - rd_ptr_r;
    assign full_s        = (level_s == (AW+1)'(DEPTH));
    assign empty_s       = (level_s == '0);
    assign rdata_s       = mem_r[rd_ptr_r[AW-1:0]];
    assign unused_addr_s = ^i_ext_addr[15:4];

    // Only a TXDATA write into a full FIFO stalls; a pop in the same cycle is not considered.
    assign txdata_sel_s = (i_ext_addr[3:0] == 4'h0);
    assign ready_s      = ~(i_ext_valid & i_ext_wstrb & txdata_sel_s & full_s);
    assign accept_s     = i_ext_valid & ready_s & ~seen_r;
    assign push_s       = accept_s & i_ext_wstrb & txdata_sel_s;

    // Seen flag: a request held valid over several cycles is accepted once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seen_r <= 1'b0;
        end else if (!i_ext_valid) begin
            seen_r <= 1'b0;
        end else if (accept_s) begin
            seen_r <= 1'b1;
        end
    end

    // Divisor register, written one byte at a time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_r <= DEFAULT_DIV;
        end else if (accept_s && i_ext_wstrb && (i_ext_addr[3:0] == 4'h4)) begin
            div_r[7:0] <= i_ext_data;
        end else if (accept_s && i_ext_wstrb && (i_ext_addr[3:0] == 4'h5)) begin
            div_r[15:8] <= i_ext_data;
        end
    end

    // FIFO pointers; one extra bit distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= i_ext_data;
        end
    end

    // Transmit state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            wdiv_r  <= DEFAULT_DIV;
            shift_r <= 8'd0;
            bit_r   <= 3'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            wdiv_r  <= wdiv_next_s;
            shift_r <= shift_next_s;
            bit_r   <= bit_next_s;
            tx_r    <= tx_next_s;
        end
    end

    // Next-state logic; each non-idle state lasts wdiv+1 clocks.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        wdiv_next_s  = wdiv_r;
        shift_next_s = shift_r;
        bit_next_s   = bit_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = rdata_s;
                    wdiv_next_s  = div_r;
                    cnt_next_s   = div_r;
                    state_next_s = ST_START;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            ST_START: begin
                if (cnt_r == 16'd0) begin
                    state_next_s = ST_DATA;
                    bit_next_s   = 3'd0;
                    cnt_next_s   = wdiv_r;
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == 16'd0) begin
                    shift_next_s = {1'b0, shift_r[7:1]};
                    cnt_next_s   = wdiv_r;
                    if (bit_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        bit_next_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_r == 16'd0) begin
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = rdata_s;
                        wdiv_next_s  = div_r;
                        cnt_next_s   = div_r;
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered so the output stays registered.
        case (state_next_s)
            ST_START: tx_next_s = 1'b0;
            ST_DATA:  tx_next_s = shift_next_s[0];
            default:  tx_next_s = 1'b1;
        endcase
    end

    assign o_ext_ready  = ready_s;
    assign o_uart_tx    = tx_r;
    assign o_busy       = (state_r != ST_IDLE) | ~empty_s;
    assign o_fifo_level = level_s;

endmodule
